// File: rtl/owire_pkg.sv
// rtl/owire_pkg.sv - command codes, slot timing and FSM states for the single-wire master
package owire_pkg;

  typedef enum logic [1:0] {IDLE, LOW, RELEASE, RECOVER} state_t;

  localparam logic [1:0] CMD_RESET = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  localparam logic [9:0] RST_L = 10'd480;
  localparam logic [9:0] RST_S = 10'd550;
  localparam logic [9:0] RST_E = 10'd960;
  localparam logic [9:0] W0_L  = 10'd60;
  localparam logic [9:0] W0_S  = 10'd15;
  localparam logic [9:0] W0_E  = 10'd65;
  localparam logic [9:0] W1_L  = 10'd6;
  localparam logic [9:0] W1_S  = 10'd15;
  localparam logic [9:0] W1_E  = 10'd65;

  typedef struct packed {
    logic [9:0] l;
    logic [9:0] s;
    logic [9:0] e;
    logic       is_reset;
  } slot_t;

  // Read and the spare code 11 share write-1 timing: a short low pulse then release.
  function automatic slot_t slot_timing(input logic [1:0] cmd, input logic wdata);
    slot_t t;
    if (cmd == CMD_RESET) begin
      t = '{l: RST_L, s: RST_S, e: RST_E, is_reset: 1'b1};
    end else if (cmd == CMD_WRITE && !wdata) begin
      t = '{l: W0_L, s: W0_S, e: W0_E, is_reset: 1'b0};
    end else begin
      t = '{l: W1_L, s: W1_S, e: W1_E, is_reset: 1'b0};
    end
    return t;
  endfunction

endpackage

// File: rtl/owire_sync2.sv
// rtl/owire_sync2.sv - two-flop synchronizer, resets to the idle (high) bus level
module owire_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/owire_master.sv
// rtl/owire_master.sv - single-wire open-drain bus master: reset/write/read slots timed in us ticks
import owire_pkg::*;

module owire_master #(
  parameter int CLKDIV = 25
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD,
  input  logic       WDATA,
  output logic       RSP_VALID,
  output logic       RSP_DATA,
  output logic       BUSY,
  output logic       PAD_I,
  output logic       PAD_T,
  input  logic       PAD_O
);

  localparam int            PW      = $clog2(CLKDIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLKDIV - 1);

  state_t        state, state_next;
  slot_t         slot;
  logic [PW-1:0] pre;
  logic [9:0]    ticks;
  logic          tick;
  logic          hit_l, hit_s, hit_e;
  logic          accept;
  logic          pad_sync;
  logic          sample;
  logic          rsp_q;
  logic          resp_bit;

  owire_sync2 u_sync (
    .clk   (CLK),
    .rst_n (RSTN),
    .d     (PAD_O),
    .q     (pad_sync)
  );

  // A hit fires in the cycle whose closing edge makes the tick count reach the target,
  // so phase changes land exactly on n*CLKDIV cycles after the accept edge.
  assign tick  = (pre == PRE_MAX);
  assign hit_l = tick && (ticks == slot.l - 10'd1);
  assign hit_s = tick && (ticks == slot.s - 10'd1);
  assign hit_e = tick && (ticks == slot.e - 10'd1);

  assign accept   = CMD_VALID && CMD_READY;
  assign resp_bit = slot.is_reset ? !sample : sample;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= IDLE;
      slot   <= '0;
      pre    <= '0;
      ticks  <= '0;
      sample <= 1'b1;
      rsp_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        slot  <= slot_timing(CMD, WDATA);
        pre   <= '0;
        ticks <= '0;
      end else begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick && ticks != 10'd1023) begin
          ticks <= ticks + 10'd1;
        end
      end
      if (hit_s && (state == LOW || state == RELEASE)) begin
        sample <= pad_sync;
      end
      if (RSP_VALID) begin
        rsp_q <= resp_bit;
      end
    end
  end

  always_comb begin
    state_next = state;
    RSP_VALID  = 1'b0;
    case (state)
      IDLE: begin
        if (CMD_VALID) state_next = LOW;
      end
      LOW: begin
        // Write-0 samples while still driving, so it skips RELEASE.
        if (hit_l) state_next = (slot.l > slot.s) ? RECOVER : RELEASE;
      end
      RELEASE: begin
        if (hit_s) state_next = RECOVER;
      end
      RECOVER: begin
        if (hit_e) begin
          RSP_VALID  = 1'b1;
          state_next = CMD_VALID ? LOW : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign CMD_READY = (state == IDLE) || RSP_VALID;
  assign BUSY      = !CMD_READY;
  assign PAD_T     = (state != LOW);
  assign PAD_I     = 1'b0;
  assign RSP_DATA  = RSP_VALID ? resp_bit : rsp_q;

endmodule
